fifo_fwft_sc: RTL and testbench

//  First-word-fall-through FIFO with early-full reserve. Sits between a producer and a consumer

---
 rtl/fifo_fwft_sc.sv | 85 ++++++++
 tb/tb_fifo_fwft_sc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_sc.sv
// Single-clock first-word-fall-through FIFO.
// full asserts RESERVE entries early so producers with pipeline slack can still land in-flight writes.
module fifo_fwft_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESERVE    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  has_data,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - RESERVE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_nx;

  logic [CW-1:0] count;
  logic [CW-1:0] vis_nx;
  logic [CW-1:0] count_nx;

  logic [1:0] rst_sync;
  logic       rd_rst;
  logic       push;
  logic       pop;

  assign rd_rst = rst_sync[1];
  assign pop    = rd_en & has_data;

  // A pop frees the slot at DEPTH, so a paired push is still legal there.
  assign push = wr_en & ~rd_rst
              & ((count != CNT_MAX) | pop);

  assign rd_ptr_nx = rd_ptr + ADDR_WIDTH'(pop);

  // Words already in storage before this edge; this edge's write stays hidden.
  assign vis_nx   = count - CW'(pop);
  assign count_nx = vis_nx + CW'(push);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      has_data <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b1;
      rd_data  <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      has_data <= (vis_nx != '0);
      empty    <= (vis_nx == '0);
      full     <= rst_sync[0] | (count_nx >= FULL_AT);
      if (vis_nx != '0) begin
        rd_data <= mem[rd_ptr_nx];
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft_sc.sv
// Randomized bench for fifo_fwft_sc.
// The reference model is a word queue plus a one-edge visibility delay.
module tb_fifo_fwft_sc;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int DEPTH   = 16;
  localparam int RESERVE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full;
  logic          has_data;
  logic          empty;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  fifo_fwft_sc #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESERVE   (RESERVE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .has_data(has_data),
    .empty   (empty)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] q[$];
  bit            fresh;
  int            rel;
  int            pushes;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_outs(string tag);
    bit hd;
    hd = (q.size() - int'(fresh)) > 0;
    chk({tag, ".full"}, 32'(full),
        32'(rel < 2 || q.size() >= DEPTH - RESERVE));
    chk({tag, ".has"}, 32'(has_data), 32'(hd));
    chk({tag, ".empty"}, 32'(empty), 32'(!hd));
    if (hd) chk({tag, ".data"}, 32'(rd_data), 32'(q[0]));
  endtask

  task automatic step(bit we, logic [DW-1:0] wd, bit re, string tag);
    bit pop;
    bit push;
    int vis;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    vis  = q.size() - int'(fresh);
    pop  = re && vis > 0;
    push = we && rel >= 2 && (q.size() < DEPTH || pop);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(wd);
      pushes++;
    end
    fresh = push;
    if (rel < 2) rel++;
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(int cyc);
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    q.delete();
    fresh = 1'b0;
    rel   = 0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      chk("rst.full", 32'(full), 32'd1);
      chk("rst.has", 32'(has_data), 32'd0);
      chk("rst.empty", 32'(empty), 32'd1);
      chk("rst.data", 32'(rd_data), 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 4 * DEPTH && q.size() > 0; i++)
      step(1'b0, '0, 1'b1, tag);
    chk({tag, ".done"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int v;
    int popped;
    int cyc;
    int p0;

    // Reset and release window
    do_reset(5);
    step(1'b0, '0, 1'b0, "rel1");
    step(1'b0, '0, 1'b0, "rel2");
    step(1'b0, '0, 1'b0, "rel3");

    // Fall-through of a single word
    step(1'b1, 8'hA5, 1'b0, "ft_wr");
    step(1'b0, '0, 1'b0, "ft_vis");
    chk("ft_a5", 32'(rd_data), 32'hA5);
    step(1'b0, '0, 1'b1, "ft_pop");
    step(1'b0, '0, 1'b0, "ft_idle");

    // Reserve threshold, paired push/pop at 13 and 16
    v = 0;
    for (int i = 0; i < 20 && !full; i++) begin
      step(1'b1, 8'(v), 1'b0, "fill");
      v++;
    end
    chk("fill_cnt", 32'(v), 32'(DEPTH - RESERVE));
    step(1'b0, '0, 1'b0, "fill_settle");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'(v), 1'b1, "pp13");
      v++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(v), 1'b0, "force");
      v++;
    end
    chk("at_depth", 32'(q.size()), 32'(DEPTH));
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'(v), 1'b1, "pp16");
      v++;
    end
    drain("drain1");

    // Streaming with random data and random gaps
    p0     = pushes;
    popped = 0;
    cyc    = 0;
    while (popped < 2000 && cyc < 20000) begin
      bit we;
      bit re;
      we = !full && ($urandom_range(0, 3) != 0);
      re = has_data && ($urandom_range(0, 3) != 0);
      if (re) popped++;
      step(we, 8'($urandom), re, "stream");
      cyc++;
    end
    chk("stream_done", 32'(popped >= 2000), 32'd1);
    chk("stream_wraps", 32'((pushes - p0) / DEPTH > 100), 32'd1);
    drain("drain2");

    // Mid-stream asynchronous reset at count 7
    for (int i = 0; i < 7; i++)
      step(1'b1, 8'($urandom), 1'b0, "pre7");
    step(1'b0, '0, 1'b0, "pre7_vis");
    chk("cnt7", 32'(q.size()), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.has", 32'(has_data), 32'd0);
    chk("arst.full", 32'(full), 32'd1);
    chk("arst.data", 32'(rd_data), 32'd0);
    do_reset(3);
    step(1'b0, '0, 1'b0, "rel1b");
    step(1'b0, '0, 1'b0, "rel2b");
    step(1'b1, 8'd1, 1'b0, "post1");
    step(1'b1, 8'd2, 1'b0, "post2");
    step(1'b1, 8'd3, 1'b0, "post3");
    step(1'b0, '0, 1'b0, "post_vis");
    chk("post_head", 32'(rd_data), 32'd1);
    drain("drain3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
